sequenciador_servos_n: RTL and testbench

//  N-channel servo sequencer: queues {canal,posicao} commands in a FIFO, executes them one at a

---
 rtl/sequenciador_servos_n.sv | 146 ++++++++++++++
 tb/tb_sequenciador_servos_n.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sequenciador_servos_n.sv
// N-channel servo sequencer: FIFO of {canal,posicao} commands, one-at-a-time execution with settle wait, one PWM per servo.
// Optional macro SEQUENCIADOR_SERVOS_DB_EN exposes the FSM state on db_estado.
//
// state     | meaning
// S_OCIOSO  | idle, waiting for a queued command
// S_CARREGA | pop FIFO head and write its position register
// S_ESPERA  | settle wait of ESPERA cycles
module sequenciador_servos_n #(
    parameter int N_SERVOS    = 3,
    parameter int N_POS       = 4,
    parameter int PERIODO     = 1_000_000,
    parameter int LARGURA_MIN = 50_000,
    parameter int PASSO_POS   = 25_000,
    parameter int ESPERA      = 25_000_000,
    parameter int PROF_FILA   = 4,
    parameter int POS_INICIAL = 0,
    localparam int CW = (N_SERVOS > 1) ? $clog2(N_SERVOS) : 1,
    localparam int PW = (N_POS > 1) ? $clog2(N_POS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [CW-1:0]       canal,
    input  logic [PW-1:0]       posicao,
    output logic                pronto,
    output logic                cheio,
    output logic                descartado,
    output logic [N_SERVOS-1:0] pwm
`ifdef SEQUENCIADOR_SERVOS_DB_EN
    ,
    output logic [1:0]          db_estado
`endif
);

    localparam int WW = $clog2(PERIODO) + 1;
    localparam int AW = $clog2(PROF_FILA);
    localparam int EW = (ESPERA > 1) ? $clog2(ESPERA) : 1;
    localparam logic [WW-1:0] LARG_MIN_W = WW'(LARGURA_MIN);
    localparam logic [WW-1:0] PASSO_W    = WW'(PASSO_POS);
    localparam logic [WW-1:0] ULTIMO     = WW'(PERIODO - 1);
    localparam logic [PW-1:0] POS_RST    = PW'(POS_INICIAL);
    localparam logic [WW-1:0] LARG_RST   = LARG_MIN_W + WW'(POS_INICIAL) * PASSO_W;

    generate
        if (LARGURA_MIN + (N_POS - 1) * PASSO_POS >= PERIODO) begin : g_chk_largura
            $error("sequenciador_servos_n: widest pulse does not fit in PERIODO");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_OCIOSO  = 2'd0,
        S_CARREGA = 2'd1,
        S_ESPERA  = 2'd2
    } estado_t;

    estado_t estado, prox;

    logic [CW+PW-1:0] fila [PROF_FILA];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      contagem;
    logic             push, pop;
    logic [CW-1:0]    cab_canal;
    logic [PW-1:0]    cab_pos;
    logic [EW-1:0]    espera_cnt;
    logic [PW-1:0]    pos_reg [N_SERVOS];
    logic [WW-1:0]    largura [N_SERVOS];
    logic [WW-1:0]    pwm_cnt;

    // cheio is the pre-edge value, so a push colliding with a pop while full is still dropped
    assign cheio  = (contagem == (AW+1)'(PROF_FILA));
    assign push   = iniciar && !cheio && (32'(canal) < N_SERVOS) && (32'(posicao) < N_POS);
    assign pronto = (estado == S_OCIOSO) && (contagem == '0);
    assign {cab_canal, cab_pos} = fila[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) fila[wr_ptr] <= {canal, posicao};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            contagem   <= '0;
            descartado <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            contagem   <= contagem + (AW+1)'(push) - (AW+1)'(pop);
            descartado <= iniciar && !push;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) estado <= S_OCIOSO;
        else       estado <= prox;
    end

    always_comb begin
        prox = estado;
        pop  = 1'b0;
        case (estado)
            S_OCIOSO:  if (contagem != '0) prox = S_CARREGA;
            S_CARREGA: begin
                pop  = 1'b1;
                prox = S_ESPERA;
            end
            S_ESPERA:  if (espera_cnt == '0) prox = (contagem != '0) ? S_CARREGA : S_OCIOSO;
            default:   prox = S_OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)                                  espera_cnt <= '0;
        else if (estado == S_CARREGA)               espera_cnt <= EW'(ESPERA - 1);
        else if (estado == S_ESPERA && espera_cnt != '0) espera_cnt <= espera_cnt - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_SERVOS; i++) pos_reg[i] <= POS_RST;
        end else if (pop) begin
            for (int i = 0; i < N_SERVOS; i++)
                if (32'(cab_canal) == i) pos_reg[i] <= cab_pos;
        end
    end

    // widths reload only at the period boundary so no pulse is ever cut or stretched
    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt <= '0;
            pwm     <= '0;
            for (int i = 0; i < N_SERVOS; i++) largura[i] <= LARG_RST;
        end else begin
            pwm_cnt <= (pwm_cnt == ULTIMO) ? '0 : pwm_cnt + 1'b1;
            for (int i = 0; i < N_SERVOS; i++) begin
                pwm[i] <= (pwm_cnt < largura[i]);
                if (pwm_cnt == ULTIMO) largura[i] <= LARG_MIN_W + WW'(pos_reg[i]) * PASSO_W;
            end
        end
    end

`ifdef SEQUENCIADOR_SERVOS_DB_EN
    assign db_estado = estado;
`endif

endmodule

// File: tb/tb_sequenciador_servos_n.sv
// Directed bench for sequenciador_servos_n with small timing parameters.
module tb_sequenciador_servos_n;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [1:0] canal = '0;
    logic [1:0] posicao = '0;
    logic       pronto, cheio, descartado;
    logic [2:0] pwm;
`ifdef SEQUENCIADOR_SERVOS_DB_EN
    logic [1:0] db_estado;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int run[3] = '{0, 0, 0};
    int last_w[3] = '{0, 0, 0};

    sequenciador_servos_n #(
        .N_SERVOS(3), .N_POS(4), .PERIODO(100), .LARGURA_MIN(10), .PASSO_POS(5),
        .ESPERA(20), .PROF_FILA(4), .POS_INICIAL(0)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .canal(canal), .posicao(posicao),
        .pronto(pronto), .cheio(cheio), .descartado(descartado), .pwm(pwm)
`ifdef SEQUENCIADOR_SERVOS_DB_EN
        , .db_estado(db_estado)
`endif
    );

    always #5 clock = ~clock;

    // length of the most recent complete high pulse on each channel
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (pwm[i] === 1'b1) run[i] = run[i] + 1;
            else begin
                if (run[i] != 0) last_w[i] = run[i];
                run[i] = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic widths(input string tag, input int w0, input int w1, input int w2);
        check({tag, "_w0"}, last_w[0], w0);
        check({tag, "_w1"}, last_w[1], w1);
        check({tag, "_w2"}, last_w[2], w2);
    endtask

    initial begin
        // 1: reset and idle PWM
        tick(2);
        reset = 1'b0;
        check("rst_pwm_first", 32'(pwm), 0);
        tick(1);
        check("rst_pwm_rise", 32'(pwm), 32'b111);
        check("rst_pronto", 32'(pronto), 1);
        check("rst_cheio", 32'(cheio), 0);
        check("rst_descartado", 32'(descartado), 0);
        tick(9);
        check("rst_pwm_9", 32'(pwm), 32'b111);
        tick(1);
        check("rst_pwm_10", 32'(pwm), 0);
        tick(200);
        widths("idle", 10, 10, 10);

        // 2: single command canal=1 posicao=3
        canal = 2'd1; posicao = 2'd3; iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        check("one_pronto_t0", 32'(pronto), 0);
        tick(21);
        check("one_pronto_t21", 32'(pronto), 0);
        tick(1);
        check("one_pronto_t22", 32'(pronto), 1);
        tick(250);
        widths("one", 10, 25, 10);

        // 3: six back-to-back pushes, sixth dropped
        iniciar = 1'b1;
        canal = 2'd0; posicao = 2'd1; tick(1);
        canal = 2'd1; posicao = 2'd2; tick(1);
        canal = 2'd2; posicao = 2'd3; tick(1);
        canal = 2'd0; posicao = 2'd2; tick(1);
        canal = 2'd1; posicao = 2'd0; tick(1);
        check("burst_cheio_t4", 32'(cheio), 1);
        check("burst_desc_t4", 32'(descartado), 0);
        canal = 2'd2; posicao = 2'd1; tick(1);
        iniciar = 1'b0;
        check("burst_desc_t5", 32'(descartado), 1);
        check("burst_cheio_t5", 32'(cheio), 1);
        tick(1);
        check("burst_desc_t6", 32'(descartado), 0);
        tick(99);
        check("burst_pronto_t105", 32'(pronto), 0);
        tick(1);
        check("burst_pronto_t106", 32'(pronto), 1);
        tick(250);
        widths("burst", 20, 10, 25);

        // 4: invalid channel is rejected and changes nothing
        canal = 2'd3; posicao = 2'd1; iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        check("inv_desc", 32'(descartado), 1);
        check("inv_pronto", 32'(pronto), 1);
        check("inv_cheio", 32'(cheio), 0);
        tick(1);
        check("inv_desc_end", 32'(descartado), 0);
        check("inv_pronto_end", 32'(pronto), 1);
        tick(250);
        widths("inv", 20, 10, 25);

        // 5: reset mid-wait drops the queue
        iniciar = 1'b1;
        canal = 2'd0; posicao = 2'd3; tick(1);
        canal = 2'd1; posicao = 2'd3; tick(1);
        canal = 2'd2; posicao = 2'd3; tick(1);
        iniciar = 1'b0;
        tick(8);
        check("abort_busy", 32'(pronto), 0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("abort_pronto", 32'(pronto), 1);
        check("abort_cheio", 32'(cheio), 0);
        tick(250);
        check("abort_pronto_late", 32'(pronto), 1);
        widths("abort", 10, 10, 10);

`ifdef SEQUENCIADOR_SERVOS_DB_EN
        // 6: debug state trace
        check("db_idle", 32'(db_estado), 0);
        canal = 2'd2; posicao = 2'd2; iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        check("db_t0", 32'(db_estado), 0);
        tick(1);
        check("db_carrega", 32'(db_estado), 1);
        tick(1);
        check("db_espera_first", 32'(db_estado), 2);
        tick(19);
        check("db_espera_last", 32'(db_estado), 2);
        tick(1);
        check("db_back_idle", 32'(db_estado), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
